// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the clock period monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MIN_PERIOD  = 4;
  localparam int DEF_MAX_PERIOD  = 1000;
  localparam int DEF_STUCK_LIMIT = 2000;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // All-ones value of a w-bit counter, used as the saturation point.
  function automatic logic [31:0] cnt_sat(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/clk_mon_sync_edge_det.sv
// Synchroniser for the asynchronous measured signal plus registered
// rise/fall pulses; pulses appear STAGES+1 clk edges after the input edge.
module sync_edge_det
  import clk_mon_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              sig_q;

  // Synchroniser chain, previous-value flop and registered edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      sig_q  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig_in};
      sig_q  <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~sig_q;
      fall   <= ~sync_q[STAGES-1] & sig_q;
    end
  end

endmodule

// File: rtl/clk_period_monitor.sv
// Measures period and high time of sig_in in clk cycles, flags bad periods
// and a stuck input, and offers results over a valid/ready port.
//
//   state | meaning
//   IDLE  | disabled, counters held at 0
//   ARM   | enabled, waiting for the first rising edge
//   MEAS  | counting between rising edges, publishing on each rise
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int MAX_PERIOD  = DEF_MAX_PERIOD,
  parameter int STUCK_LIMIT = DEF_STUCK_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_err,
  output logic             overrun,
  output logic             stuck,
  output logic [7:0]       err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(cnt_sat(CNT_W));
  localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_P     = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] STUCK_LIM = CNT_W'(STUCK_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic             rise, fall;
  logic [CNT_W-1:0] pcnt, hcnt, pcnt_inc, hcnt_inc;
  logic             high_open;
  logic             start, publish, stuck_hit, err_now;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  assign pcnt_inc = (pcnt == CNT_MAX) ? pcnt : pcnt + CNT_ONE;
  assign hcnt_inc = (hcnt == CNT_MAX) ? hcnt : hcnt + CNT_ONE;
  assign err_now  = (pcnt < MIN_P) || (pcnt > MAX_P);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    publish   = 1'b0;
    stuck_hit = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = ARM;
      ARM: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (rise) begin
          start     = 1'b1;
          state_nxt = MEAS;
        end
      end
      MEAS: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (rise) begin
          publish = 1'b1;
          start   = 1'b1;
        end else if (pcnt >= STUCK_LIM) begin
          stuck_hit = 1'b1;
          state_nxt = ARM;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Period/high counters; a fall freezes the high count for this period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt      <= '0;
      hcnt      <= '0;
      high_open <= 1'b0;
    end else if (start) begin
      pcnt      <= CNT_ONE;
      hcnt      <= CNT_ONE;
      high_open <= 1'b1;
    end else if (state == MEAS && en && !stuck_hit) begin
      pcnt <= pcnt_inc;
      if (fall)           high_open <= 1'b0;
      else if (high_open) hcnt      <= hcnt_inc;
    end else begin
      pcnt      <= '0;
      hcnt      <= '0;
      high_open <= 1'b0;
    end
  end

  // Result registers, handshake, sticky flags and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      period_err <= 1'b0;
      overrun    <= 1'b0;
      stuck      <= 1'b0;
      err_count  <= '0;
    end else begin
      if (publish) begin
        period     <= pcnt;
        high_time  <= hcnt;
        period_err <= err_now;
        meas_valid <= 1'b1;
        if (meas_valid && !meas_ready) overrun <= 1'b1;
        if (err_now && err_count != ERR_CNT_MAX) err_count <= err_count + 8'd1;
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
      // Publishing never happens with en low, so this cannot race a set.
      if (!en) overrun <= 1'b0;
      if (stuck_hit)  stuck <= 1'b1;
      else if (start) stuck <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor: 10-unit clk, sig_in generator with
// programmable high/low times aligned to clk negedges.
module tb_clk_period_monitor;
  import clk_mon_pkg::*;

  localparam int CNT_W = 16;
  localparam int STUCK_LIMIT = 2000;

  logic             clk, rst_n, en, sig_in, meas_ready;
  logic             meas_valid, period_err, overrun, stuck;
  logic [CNT_W-1:0] period, high_time;
  logic [7:0]       err_count;

  int checks = 0;
  int errors = 0;

  bit gen_on = 1'b0;
  int gen_hi = 50;
  int gen_lo = 50;

  clk_period_monitor #(
    .CNT_W(CNT_W), .SYNC_STAGES(2), .MIN_PERIOD(4),
    .MAX_PERIOD(1000), .STUCK_LIMIT(STUCK_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .meas_valid(meas_valid), .meas_ready(meas_ready),
    .period(period), .high_time(high_time), .period_err(period_err),
    .overrun(overrun), .stuck(stuck), .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      if (gen_on) begin
        sig_in = 1'b1;
        #(gen_hi);
        sig_in = 1'b0;
        #(gen_lo);
      end else begin
        sig_in = 1'b0;
        #10;
      end
    end
  end

  task automatic wait_result(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (meas_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    gen_on = 1'b0;
    en = 1'b0;
    meas_ready = 1'b1;
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_gen(input int hi, input int lo);
    gen_hi = hi;
    gen_lo = lo;
    en = 1'b1;
    repeat (2) @(negedge clk);
    gen_on = 1'b1;
  endtask

  task automatic test_reset();
    gen_on = 1'b0;
    en = 1'b0;
    meas_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({meas_valid, period, high_time, period_err, overrun, stuck, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b period=%0d high=%0d err=%b ovr=%b stuck=%b cnt=%0d, want all 0",
               meas_valid, period, high_time, period_err, overrun, stuck, err_count);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, want IDLE", dut.state);
    end
    repeat (7) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (meas_valid !== 1'b0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL idle_disabled: got valid=%b state=%0d, want 0/IDLE", meas_valid, dut.state);
    end
  endtask

  task automatic test_period_50();
    bit got;
    do_reset();
    start_gen(50, 50);
    for (int k = 0; k < 3; k++) begin
      wait_result(40, got);
      checks++;
      if (!got || period !== 16'd10 || high_time !== 16'd5 || period_err !== 1'b0) begin
        errors++;
        $display("FAIL period_50[%0d]: got valid=%b period=%0d high=%0d err=%b, want 10/5/0",
                 k, got, period, high_time, period_err);
      end
    end
  endtask

  task automatic test_duty_30();
    bit got;
    do_reset();
    start_gen(30, 70);
    for (int k = 0; k < 3; k++) begin
      wait_result(40, got);
      checks++;
      if (!got || period !== 16'd10 || high_time !== 16'd3 || period_err !== 1'b0) begin
        errors++;
        $display("FAIL duty_30[%0d]: got valid=%b period=%0d high=%0d err=%b, want 10/3/0",
                 k, got, period, high_time, period_err);
      end
    end
  endtask

  task automatic test_period_err();
    bit got;
    do_reset();
    start_gen(10, 10);
    for (int k = 1; k <= 5; k++) begin
      wait_result(10, got);
      checks++;
      if (!got || period !== 16'd2 || high_time !== 16'd1 || period_err !== 1'b1 ||
          err_count !== 8'(k)) begin
        errors++;
        $display("FAIL short_period[%0d]: got valid=%b period=%0d high=%0d err=%b cnt=%0d, want 2/1/1/%0d",
                 k, got, period, high_time, period_err, err_count, k);
      end
    end
    repeat (600) @(negedge clk);
    checks++;
    if (err_count !== 8'd255 || period_err !== 1'b1) begin
      errors++;
      $display("FAIL err_count_sat: got cnt=%0d err=%b, want 255/1", err_count, period_err);
    end
  endtask

  task automatic test_stuck();
    bit got;
    bit saw_valid;
    bit cleared;
    do_reset();
    start_gen(50, 50);
    wait_result(40, got);
    checks++;
    if (!got || period !== 16'd10) begin
      errors++;
      $display("FAIL stuck_lock: got valid=%b period=%0d, want 1/10", got, period);
    end
    gen_on = 1'b0;
    repeat (STUCK_LIMIT - 1) @(negedge clk);
    checks++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL stuck_early: got %b one cycle before limit, want 0", stuck);
    end
    @(negedge clk);
    checks++;
    if (stuck !== 1'b1 || meas_valid !== 1'b0) begin
      errors++;
      $display("FAIL stuck_set: got stuck=%b valid=%b at limit, want 1/0", stuck, meas_valid);
    end
    gen_on = 1'b1;
    saw_valid = 1'b0;
    cleared = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (meas_valid) saw_valid = 1'b1;
      if (!stuck) begin
        cleared = 1'b1;
        break;
      end
    end
    checks++;
    if (!cleared || saw_valid) begin
      errors++;
      $display("FAIL stuck_clear: got cleared=%b result_seen=%b, want 1/0", cleared, saw_valid);
    end
    wait_result(15, got);
    checks++;
    if (!got || period !== 16'd10 || high_time !== 16'd5 || period_err !== 1'b0 || stuck !== 1'b0) begin
      errors++;
      $display("FAIL stuck_relock: got valid=%b period=%0d high=%0d err=%b stuck=%b, want 1/10/5/0/0",
               got, period, high_time, period_err, stuck);
    end
  endtask

  task automatic test_overrun();
    bit got;
    do_reset();
    start_gen(50, 50);
    wait_result(40, got);
    meas_ready = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (!got || meas_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL hold_unread: got first=%b valid=%b ovr=%b, want 1/1/0", got, meas_valid, overrun);
    end
    @(negedge clk);
    checks++;
    if (meas_valid !== 1'b1 || overrun !== 1'b1 || period !== 16'd10 || high_time !== 16'd5) begin
      errors++;
      $display("FAIL overwrite: got valid=%b ovr=%b period=%0d high=%0d, want 1/1/10/5",
               meas_valid, overrun, period, high_time);
    end
    repeat (2) @(negedge clk);
    meas_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (meas_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL one_transfer: got valid=%b ovr=%b, want 0/1", meas_valid, overrun);
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0 || meas_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_clears_ovr: got ovr=%b valid=%b, want 0/0", overrun, meas_valid);
    end
  endtask

  task automatic test_async_reset();
    bit got;
    int n;
    do_reset();
    start_gen(50, 50);
    wait_result(40, got);
    checks++;
    if (!got || period !== 16'd10) begin
      errors++;
      $display("FAIL pre_reset: got valid=%b period=%0d, want 1/10", got, period);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({meas_valid, period, high_time, period_err, overrun, stuck, err_count} !== '0 ||
        dut.state !== IDLE) begin
      errors++;
      $display("FAIL async_reset: got valid=%b period=%0d high=%0d state=%0d, want 0/0/0/IDLE",
               meas_valid, period, high_time, dut.state);
    end
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (meas_valid) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || n != 18 || period !== 16'd10 || high_time !== 16'd5) begin
      errors++;
      $display("FAIL two_rises_after_reset: got valid=%b cycles=%0d period=%0d high=%0d, want 1/18/10/5",
               got, n, period, high_time);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    meas_ready = 1'b1;
    test_reset();
    test_period_50();
    test_duty_30();
    test_period_err();
    test_stuck();
    test_overrun();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
